gray_decoder: RTL and testbench
===============================

# gray_decoder

Receive-side companion to the team's 3-bit gray-code up-counter. The block samples a gray-coded count on a valid strobe and converts it to binary. It checks that each new sample is the same code or exactly one step forward, and counts wrap-arounds. It sits at the consumer end of any link that carries a gray-coded counter across, and gives downstream logic a registered binary count plus sticky overflow and error status.

## Interface
- WIDTH, default 3: width of the gray and binary code, in bits. Legal values are WIDTH ≥ 2.
- Clk  input  1  sole clock, rising-edge.
- Reset  input  1  synchronous, active-low reset. When low at a Clk edge, every register returns to its reset value. Reset has priority over all other inputs.
- Valid  input  1  sample strobe. Gray is sampled on a Clk edge where Valid=1.
- Gray  input  WIDTH  gray-coded count.
- Binary  output  WIDTH  registered binary value of the last accepted sample. Reset value is 0.
- Step  output  1  one-cycle pulse on each accepted forward step. Reset value is 0.
- Overflow  output  1  sticky; set on the first wrap from all-ones to 0. Reset value is 0.
- WrapCount  output  8  number of wraps seen, saturating at 255. Reset value is 0.
- Error  output  1  sticky; set on an illegal transition. Reset value is 0.

## Operation
- Combinational decode of the input:
  - nb[WIDTH-1] = Gray[WIDTH-1]
  - nb[i] = nb[i+1] ^ Gray[i], for i = WIDTH-2 down to 0.
- FSM states: IDLE, TRACK and ERR. Reset state is IDLE.
- IDLE:
  - Valid=1: Binary <= nb, go to TRACK. No legality check is made. Step stays 0.
  - Valid=0: stay in IDLE.
- TRACK, on Valid=1:
  - nb == Binary: this is a stall. No register changes and Step=0.
  - nb == Binary+1 (mod 2^WIDTH): this is an accepted step. Binary <= nb and Step=1 for the next cycle.
  - Accepted step with Binary == all-ones and nb == 0:
    - Overflow <= 1.
    - WrapCount <= WrapCount+1, unless it is already 255, in which case it holds.
  - Any other nb: Error <= 1, go to ERR. Binary keeps its last good value and Step=0.
- TRACK, on Valid=0: hold all registers and drive Step=0.
- ERR: Valid is ignored. Outputs hold and Step=0. The only exit is Reset low.
- Backward steps, including all-ones back to all-ones-1, are errors. The block is forward-only.
- WrapCount arithmetic is 8-bit unsigned with explicit saturation; it never rolls over to 0.

## Timing
- Latency: a sample taken at edge N is visible on Binary, Step, Overflow, WrapCount and Error after edge N. All outputs are registered with no combinational path from input to output.
- Step is high for exactly one cycle per accepted step. Back-to-back accepted steps give a continuously high Step.
- Reset low during any state takes effect at that edge and overrides a simultaneous Valid. On the following edges with Reset high, the block behaves as if freshly started in IDLE.
- Overflow and Error clear only on reset.
- A wrap and a saturated WrapCount in the same cycle: Overflow stays 1, WrapCount stays 255, Step=1.

## Test plan
- Forward sequence, WIDTH=3: reset, then Valid on each of 000, 001, 011, 010, 110, 111, 101, 100, 000. Binary steps 0→7→0. Step pulses 8 times, the first sample does not pulse. Overflow goes 1 after the last sample. WrapCount=1. Error=0.
- Stall and gaps: samples 001, 001, then Valid=0 for 3 cycles, then 011. Binary goes 1, 1, 1, 2. Step pulses only on the 011 sample.
- Illegal jump: samples 000 then 011 (binary 2). Error=1 and the FSM is in ERR. Binary holds 0. A further Valid on 001 changes nothing.
- Backward step: samples 010 (binary 3) then 011 (binary 2). Error=1 and Binary holds 3.
- Reset mid-operation: after 5 accepted steps, drive Reset low for one edge while Valid=1. All outputs are 0 and the FSM is in IDLE. Then sample 110: Binary=4, Step=0, no error.
- Saturation: run 256 full wraps (2048 accepted steps). WrapCount reads 255 from wrap 255 onward. Overflow=1 and Error=0 throughout.

Source files
------------

// File: rtl/gray_decoder_if.sv
// Sample bus between a gray-code source and gray_decoder.
// The source drives Valid/Gray and observes the decoded status.
interface gray_decoder_if #(parameter int WIDTH = 3);
   logic             Valid;
   logic [WIDTH-1:0] Gray;
   logic [WIDTH-1:0] Binary;
   logic             Step;
   logic             Overflow;
   logic [7:0]       WrapCount;
   logic             Error;

   modport master (output Valid, Gray,
                   input  Binary, Step, Overflow, WrapCount, Error);
   modport slave  (input  Valid, Gray,
                   output Binary, Step, Overflow, WrapCount, Error);
endinterface

// File: rtl/gray_decoder.sv
// Receive-side gray-to-binary decoder. Tracks a forward-only gray counter,
// flags illegal transitions and counts wraps with a saturating counter.
module gray_decoder #(parameter int WIDTH = 3) (
   input logic           Clk,
   input logic           Reset,
   gray_decoder_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] TRACK = 2'd1;
   localparam logic [1:0] ERR   = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] nb, binary_q, bin_inc;
   logic             step_q, ovf_q, err_q;
   logic [7:0]       wrap_q;

   // Each binary bit is the XOR of all gray bits at or above it.
   always_comb begin
      nb = '0;
      nb[WIDTH-1] = bus.Gray[WIDTH-1];
      for (int i = WIDTH-2; i >= 0; i--)
         nb[i] = nb[i+1] ^ bus.Gray[i];
   end

   assign bin_inc = binary_q + 1'b1;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state    <= IDLE;
         binary_q <= '0;
         step_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wrap_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         step_q <= 1'b0;
         case (state)
            IDLE: if (bus.Valid) begin
               binary_q <= nb;
               state    <= TRACK;
            end
            TRACK: if (bus.Valid && nb != binary_q) begin
               if (nb == bin_inc) begin
                  binary_q <= nb;
                  step_q   <= 1'b1;
                  // A forward step out of all-ones can only land on zero.
                  if (binary_q == '1) begin
                     ovf_q <= 1'b1;
                     if (wrap_q != 8'hFF) wrap_q <= wrap_q + 8'd1;
                  end
               end else begin
                  err_q <= 1'b1;
                  state <= ERR;
               end
            end
            default: state <= state;
         endcase
      end
   end

   assign bus.Binary    = binary_q;
   assign bus.Step      = step_q;
   assign bus.Overflow  = ovf_q;
   assign bus.WrapCount = wrap_q;
   assign bus.Error     = err_q;
endmodule

// File: tb/tb_gray_decoder.sv
// Directed self-checking bench for gray_decoder with WIDTH=3.
module tb_gray_decoder;
   logic Clk = 1'b0;
   logic Reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   gray_decoder_if #(.WIDTH(3)) bus();
   gray_decoder #(.WIDTH(3)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));

   always #5 Clk = ~Clk;

   // Gray code for binary index k, and its decoded value k.
   logic [2:0] gt [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b0; bus.Valid = 1'b0; bus.Gray = '0;
      @(posedge Clk); #1;
      Reset = 1'b1;
   endtask

   task automatic sample(input logic [2:0] g);
      @(negedge Clk);
      bus.Valid = 1'b1; bus.Gray = g;
      @(posedge Clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         bus.Valid = 1'b0;
         @(posedge Clk); #1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.Binary !== 3'd0) begin bad++; $display("FAIL reset_binary got=%0d want=0", bus.Binary); end
      total++; if (bus.Step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", bus.Step); end
      total++; if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.Overflow); end
      total++; if (bus.WrapCount !== 8'd0) begin bad++; $display("FAIL reset_wrap got=%0d want=0", bus.WrapCount); end
      total++; if (bus.Error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.Error); end
   endtask

   task automatic test_forward();
      logic [2:0] seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      logic [2:0] exb [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         sample(seq[i]);
         if (bus.Step === 1'b1) pulses++;
         total++; if (bus.Binary !== exb[i]) begin bad++; $display("FAIL fwd_binary[%0d] got=%0d want=%0d", i, bus.Binary, exb[i]); end
         total++; if (bus.Step !== (i != 0)) begin bad++; $display("FAIL fwd_step[%0d] got=%b want=%b", i, bus.Step, i != 0); end
         total++; if (bus.Overflow !== (i == 8)) begin bad++; $display("FAIL fwd_ovf[%0d] got=%b want=%b", i, bus.Overflow, i == 8); end
      end
      total++; if (pulses != 8) begin bad++; $display("FAIL fwd_pulses got=%0d want=8", pulses); end
      total++; if (bus.WrapCount !== 8'd1) begin bad++; $display("FAIL fwd_wrap got=%0d want=1", bus.WrapCount); end
      total++; if (bus.Error !== 1'b0) begin bad++; $display("FAIL fwd_err got=%b want=0", bus.Error); end
      idle(1);
      total++; if (bus.Step !== 1'b0) begin bad++; $display("FAIL fwd_step_drop got=%b want=0", bus.Step); end
   endtask

   task automatic test_stall();
      do_reset();
      sample(3'b001);
      total++; if (bus.Binary !== 3'd1 || bus.Step !== 1'b0) begin bad++; $display("FAIL stall_first got=%0d/%b want=1/0", bus.Binary, bus.Step); end
      sample(3'b001);
      total++; if (bus.Binary !== 3'd1 || bus.Step !== 1'b0) begin bad++; $display("FAIL stall_repeat got=%0d/%b want=1/0", bus.Binary, bus.Step); end
      for (int i = 0; i < 3; i++) begin
         idle(1);
         total++; if (bus.Binary !== 3'd1 || bus.Step !== 1'b0) begin bad++; $display("FAIL stall_gap[%0d] got=%0d/%b want=1/0", i, bus.Binary, bus.Step); end
      end
      sample(3'b011);
      total++; if (bus.Binary !== 3'd2 || bus.Step !== 1'b1) begin bad++; $display("FAIL stall_step got=%0d/%b want=2/1", bus.Binary, bus.Step); end
      total++; if (bus.Error !== 1'b0) begin bad++; $display("FAIL stall_err got=%b want=0", bus.Error); end
   endtask

   task automatic test_illegal();
      do_reset();
      sample(3'b000);
      sample(3'b011);
      total++; if (bus.Error !== 1'b1) begin bad++; $display("FAIL jump_err got=%b want=1", bus.Error); end
      total++; if (bus.Binary !== 3'd0 || bus.Step !== 1'b0) begin bad++; $display("FAIL jump_hold got=%0d/%b want=0/0", bus.Binary, bus.Step); end
      // 001 would be a legal step from 0 if the block were still tracking.
      sample(3'b001);
      total++; if (bus.Binary !== 3'd0 || bus.Step !== 1'b0) begin bad++; $display("FAIL jump_locked got=%0d/%b want=0/0", bus.Binary, bus.Step); end
      total++; if (bus.Error !== 1'b1) begin bad++; $display("FAIL jump_sticky got=%b want=1", bus.Error); end
   endtask

   task automatic test_backward();
      do_reset();
      sample(3'b010);
      sample(3'b011);
      total++; if (bus.Error !== 1'b1 || bus.Binary !== 3'd3) begin bad++; $display("FAIL back_err got=%b/%0d want=1/3", bus.Error, bus.Binary); end
      do_reset();
      sample(3'b100);
      sample(3'b101);
      total++; if (bus.Error !== 1'b1 || bus.Binary !== 3'd7) begin bad++; $display("FAIL back_top got=%b/%0d want=1/7", bus.Error, bus.Binary); end
      total++; if (bus.Overflow !== 1'b0 || bus.Step !== 1'b0) begin bad++; $display("FAIL back_top_flags got=%b/%b want=0/0", bus.Overflow, bus.Step); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      // Start at 7 so the five steps include a wrap: 0,1,2,3,4.
      sample(3'b100);
      sample(3'b000); sample(3'b001); sample(3'b011); sample(3'b010); sample(3'b110);
      total++; if (bus.Binary !== 3'd4 || bus.Overflow !== 1'b1 || bus.WrapCount !== 8'd1) begin bad++; $display("FAIL mid_pre got=%0d/%b/%0d want=4/1/1", bus.Binary, bus.Overflow, bus.WrapCount); end
      @(negedge Clk);
      Reset = 1'b0; bus.Valid = 1'b1; bus.Gray = 3'b111;
      @(posedge Clk); #1;
      total++; if (bus.Binary !== 3'd0 || bus.Step !== 1'b0 || bus.Overflow !== 1'b0 || bus.WrapCount !== 8'd0 || bus.Error !== 1'b0) begin
         bad++; $display("FAIL mid_reset got=%0d/%b/%b/%0d/%b want=0/0/0/0/0", bus.Binary, bus.Step, bus.Overflow, bus.WrapCount, bus.Error);
      end
      Reset = 1'b1;
      sample(3'b110);
      total++; if (bus.Binary !== 3'd4 || bus.Step !== 1'b0 || bus.Error !== 1'b0) begin bad++; $display("FAIL mid_restart got=%0d/%b/%b want=4/0/0", bus.Binary, bus.Step, bus.Error); end
   endtask

   task automatic test_saturation();
      int want;
      do_reset();
      sample(3'b000);
      for (int w = 1; w <= 256; w++) begin
         for (int k = 1; k <= 8; k++) begin
            sample(gt[k % 8]);
            total++; if (bus.Binary !== 3'(k % 8) || bus.Step !== 1'b1 || bus.Error !== 1'b0) begin
               bad++; $display("FAIL sat_step w=%0d k=%0d got=%0d/%b/%b want=%0d/1/0", w, k, bus.Binary, bus.Step, bus.Error, k % 8);
            end
         end
         want = (w > 255) ? 255 : w;
         total++; if (bus.WrapCount !== 8'(want) || bus.Overflow !== 1'b1) begin
            bad++; $display("FAIL sat_wrap w=%0d got=%0d/%b want=%0d/1", w, bus.WrapCount, bus.Overflow, want);
         end
      end
   endtask

   initial begin
      bus.Valid = 1'b0;
      bus.Gray  = '0;
      test_reset();
      test_forward();
      test_stall();
      test_illegal();
      test_backward();
      test_reset_mid();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
